// File: rtl/x1_mode_pkg.sv
// ============================================================================
// Module  : x1_mode_pkg
// Brief   : Shared constants for the x1 mode bank (readback layout, defaults).
// Rev     : 1.0
// ============================================================================
`default_nettype none

package x1_mode_pkg;

  localparam int RB_W              = 8;
  localparam int RB_MODE_LSB       = 0;
  localparam int STALL_MAX_DEFAULT = 255;

  // Bus activity is the pair {wr, rd}; idle when both are low.
  localparam int                    BUS_IDLE_W = 2;
  localparam logic [BUS_IDLE_W-1:0] BUS_IDLE   = '0;

  function automatic int rb_evt_lsb(input int num_modes);
    return RB_MODE_LSB + num_modes;
  endfunction

  function automatic int cnt_width(input int stall_max);
    if (stall_max < 1) begin
      return 1;
    end
    return $clog2(stall_max + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/x1_evt_latch.sv
// ============================================================================
// Module  : x1_evt_latch
// Brief   : One deferred event: raw flag plus visible copy loaded on demand.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module x1_evt_latch (
  input  logic clk_i,
  input  logic rst_i,
  input  logic set_i,
  input  logic clr_i,
  input  logic load_i,
  output logic raw_o,
  output logic vis_o
);

  logic raw_q, raw_d;
  logic vis_q, vis_d;

  always_comb begin
    raw_d = raw_q;
    if (clr_i) begin
      raw_d = 1'b0;
    end else if (set_i) begin
      raw_d = 1'b1;
    end
    // Visible copy takes the pre-edge raw value, so a set needs two edges to show.
    vis_d = load_i ? raw_q : vis_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      raw_q <= 1'b0;
      vis_q <= 1'b0;
    end else begin
      raw_q <= raw_d;
      vis_q <= vis_d;
    end
  end

  assign raw_o = raw_q;
  assign vis_o = vis_q;

endmodule

`default_nettype wire

// File: rtl/x1_mode_bank.sv
// ============================================================================
// Module  : x1_mode_bank
// Brief   : Set/reset mode bits with deferred event flags; optional status
//           readback enabled by X1_MODE_BANK_READBACK_EN.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module x1_mode_bank
  import x1_mode_pkg::*;
#(
  parameter int                   NUM_MODES = 4,
  parameter int                   NUM_EVT   = 2,
  parameter logic [NUM_MODES-1:0] MODE_RST  = NUM_MODES'(1),
  parameter int                   STALL_MAX = STALL_MAX_DEFAULT
) (
  input  logic                 C_CLK,
  input  logic                 I_RESET,
  input  logic                 I_RD,
  input  logic                 I_WR,
  input  logic [NUM_MODES-1:0] I_SET_CS,
  input  logic [NUM_MODES-1:0] I_RES_CS,
  input  logic                 I_STAT_CS,
  input  logic [NUM_EVT-1:0]   I_EVT_SET,
  input  logic [NUM_EVT-1:0]   I_EVT_CLR,
  output logic [NUM_MODES-1:0] O_MODE,
  output logic [NUM_EVT-1:0]   O_EVT,
  output logic                 O_PEND,
  output logic [RB_W-1:0]      O_Q
);

  localparam int               CNT_W   = cnt_width(STALL_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_MAX);
  localparam int               EVT_LSB = rb_evt_lsb(NUM_MODES);

  logic                 wr_q, wr_d;
  logic [NUM_MODES-1:0] mode_q, mode_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 wr_rise;
  logic                 bus_idle;
  logic                 force_upd;
  logic                 evt_load;
  logic [NUM_EVT-1:0]   evt_raw;

  assign bus_idle = ({I_WR, I_RD} == BUS_IDLE);
  assign wr_rise  = I_WR & ~wr_q;
  assign wr_d     = I_WR;

  always_comb begin
    mode_d = mode_q;
    if (wr_rise) begin
      mode_d = I_SET_CS | (mode_q & ~I_RES_CS);
    end
  end

  // Busy counter saturates; reaching the limit forces the deferred update.
  always_comb begin
    cnt_d     = cnt_q;
    force_upd = 1'b0;
    if (bus_idle) begin
      cnt_d = '0;
    end else if ((STALL_MAX != 0) && (cnt_q == CNT_MAX)) begin
      cnt_d     = '0;
      force_upd = 1'b1;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign evt_load = bus_idle | force_upd;

  always_ff @(posedge C_CLK) begin
    if (I_RESET) begin
      wr_q   <= 1'b1;
      mode_q <= MODE_RST;
      cnt_q  <= '0;
    end else begin
      wr_q   <= wr_d;
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
    end
  end

  generate
    for (genvar k = 0; k < NUM_EVT; k++) begin : g_evt
      x1_evt_latch u_evt (
        .clk_i  (C_CLK),
        .rst_i  (I_RESET),
        .set_i  (I_EVT_SET[k]),
        .clr_i  (I_EVT_CLR[k]),
        .load_i (evt_load),
        .raw_o  (evt_raw[k]),
        .vis_o  (O_EVT[k])
      );
    end
  endgenerate

  assign O_MODE = mode_q;
  assign O_PEND = (evt_raw != O_EVT);

`ifdef X1_MODE_BANK_READBACK_EN
  logic [RB_W-1:0] q_q, q_d;

  always_comb begin
    q_d = '0;
    if (I_RD & I_STAT_CS) begin
      q_d[RB_MODE_LSB +: NUM_MODES] = mode_q;
      q_d[EVT_LSB +: NUM_EVT]       = O_EVT;
    end
  end

  always_ff @(posedge C_CLK) begin
    if (I_RESET) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign O_Q = q_q;
`else
  logic unused_stat_cs;
  assign unused_stat_cs = I_STAT_CS;
  assign O_Q            = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_x1_mode_bank.sv
// ============================================================================
// Module  : tb_x1_mode_bank
// Brief   : Directed vector table plus randomized run against a rule model.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_x1_mode_bank;

  localparam int         NM   = 4;
  localparam int         NE   = 2;
  localparam int         SM   = 4;
  localparam logic [3:0] MRST = 4'b0001;
`ifdef X1_MODE_BANK_READBACK_EN
  localparam bit RB_EN = 1'b1;
`else
  localparam bit RB_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, rd, wr, stat;
  logic [NM-1:0] set_cs, res_cs;
  logic [NE-1:0] es, ec;
  logic [NM-1:0] mode;
  logic [NE-1:0] evt;
  logic          pend;
  logic [7:0]    q;

  always #5 clk = ~clk;

  x1_mode_bank #(
    .NUM_MODES (NM),
    .NUM_EVT   (NE),
    .MODE_RST  (MRST),
    .STALL_MAX (SM)
  ) dut (
    .C_CLK     (clk),
    .I_RESET   (rst),
    .I_RD      (rd),
    .I_WR      (wr),
    .I_SET_CS  (set_cs),
    .I_RES_CS  (res_cs),
    .I_STAT_CS (stat),
    .I_EVT_SET (es),
    .I_EVT_CLR (ec),
    .O_MODE    (mode),
    .O_EVT     (evt),
    .O_PEND    (pend),
    .O_Q       (q)
  );

  typedef struct {
    bit       rst, wr, rd;
    bit [3:0] set, res;
    bit       stat;
    bit [1:0] es, ec;
    bit [3:0] emode;
    bit [1:0] eevt;
    bit       epend;
    bit [7:0] eq;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(bit r, bit w, bit d, bit [3:0] s, bit [3:0] c, bit st,
                              bit [1:0] e_s, bit [1:0] e_c, bit [3:0] em, bit [1:0] ee,
                              bit ep, bit [7:0] eq);
    vec_t v;
    v.rst = r; v.wr = w; v.rd = d; v.set = s; v.res = c; v.stat = st;
    v.es = e_s; v.ec = e_c; v.emode = em; v.eevt = ee; v.epend = ep; v.eq = eq;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit w, input bit d, input bit [3:0] s,
                       input bit [3:0] c, input bit st, input bit [1:0] e_s, input bit [1:0] e_c);
    rst = r; wr = w; rd = d; set_cs = s; res_cs = c; stat = st; es = e_s; ec = e_c;
  endtask

  // Reference state, held as plain integers and updated from the stated rules.
  int m_mode, m_raw, m_vis, m_cnt, m_q;
  bit m_wrp;

  task automatic model_step();
    int  old_raw;
    bit  busy, rise;
    old_raw = m_raw;
    busy    = wr || rd;
    rise    = wr && !m_wrp;
    if (rst) begin
      m_mode = MRST; m_raw = 0; m_vis = 0; m_cnt = 0; m_wrp = 1'b1; m_q = 0;
    end else begin
      m_q = (RB_EN && rd && stat) ? (m_vis * (1 << NM) + m_mode) : 0;
      if (rise) begin
        for (int k = 0; k < NM; k++) begin
          if (set_cs[k])      m_mode = m_mode | (1 << k);
          else if (res_cs[k]) m_mode = m_mode & ~(1 << k);
        end
      end
      for (int k = 0; k < NE; k++) begin
        if (ec[k])      m_raw = m_raw & ~(1 << k);
        else if (es[k]) m_raw = m_raw | (1 << k);
      end
      if (!busy) begin
        m_vis = old_raw; m_cnt = 0;
      end else if (SM != 0 && m_cnt == SM) begin
        m_vis = old_raw; m_cnt = 0;
      end else if (m_cnt < SM) begin
        m_cnt = m_cnt + 1;
      end
      m_wrp = wr;
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);

    tbl.push_back(mk(1,0,0, 4'h0,4'h0,0, 2'd0,2'd0, 4'h1,2'd0,0,8'h00));
    tbl.push_back(mk(0,0,0, 4'h0,4'h0,0, 2'd0,2'd0, 4'h1,2'd0,0,8'h00));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,1,0, 4'h4,4'h0,0, 2'd0,2'd0, 4'h5,2'd0,0,8'h00));
    tbl.push_back(mk(0,0,0, 4'h0,4'h0,0, 2'd0,2'd0, 4'h5,2'd0,0,8'h00));
    tbl.push_back(mk(1,1,0, 4'h0,4'h1,0, 2'd0,2'd0, 4'h1,2'd0,0,8'h00));
    tbl.push_back(mk(0,1,0, 4'h0,4'h1,0, 2'd0,2'd0, 4'h1,2'd0,0,8'h00));
    tbl.push_back(mk(0,1,0, 4'h0,4'h1,0, 2'd0,2'd0, 4'h1,2'd0,0,8'h00));
    tbl.push_back(mk(0,0,0, 4'h0,4'h0,0, 2'd0,2'd0, 4'h1,2'd0,0,8'h00));
    tbl.push_back(mk(0,1,0, 4'h0,4'h1,0, 2'd0,2'd0, 4'h0,2'd0,0,8'h00));
    tbl.push_back(mk(0,0,0, 4'h0,4'h0,0, 2'd0,2'd0, 4'h0,2'd0,0,8'h00));
    tbl.push_back(mk(0,1,0, 4'h6,4'h6,0, 2'd0,2'd0, 4'h6,2'd0,0,8'h00));
    tbl.push_back(mk(0,0,0, 4'h0,4'h0,0, 2'd0,2'd0, 4'h6,2'd0,0,8'h00));
    tbl.push_back(mk(0,1,0, 4'h8,4'h2,0, 2'd0,2'd0, 4'hC,2'd0,0,8'h00));
    tbl.push_back(mk(0,0,0, 4'h0,4'h0,0, 2'd0,2'd0, 4'hC,2'd0,0,8'h00));
    tbl.push_back(mk(0,0,0, 4'h0,4'h0,0, 2'd1,2'd0, 4'hC,2'd0,1,8'h00));
    tbl.push_back(mk(0,0,0, 4'h0,4'h0,0, 2'd0,2'd0, 4'hC,2'd1,0,8'h00));
    tbl.push_back(mk(0,0,0, 4'h0,4'h0,0, 2'd2,2'd2, 4'hC,2'd1,0,8'h00));
    tbl.push_back(mk(0,0,0, 4'h0,4'h0,0, 2'd0,2'd0, 4'hC,2'd1,0,8'h00));
    tbl.push_back(mk(0,0,0, 4'h0,4'h0,0, 2'd0,2'd1, 4'hC,2'd1,1,8'h00));
    tbl.push_back(mk(0,0,0, 4'h0,4'h0,0, 2'd0,2'd0, 4'hC,2'd0,0,8'h00));
    // Read held busy: forced update lands on the fifth busy edge, then again five later.
    tbl.push_back(mk(0,0,1, 4'h0,4'h0,0, 2'd1,2'd0, 4'hC,2'd0,1,8'h00));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,0,1, 4'h0,4'h0,0, 2'd0,2'd0, 4'hC,2'd0,1,8'h00));
    tbl.push_back(mk(0,0,1, 4'h0,4'h0,0, 2'd0,2'd0, 4'hC,2'd1,0,8'h00));
    tbl.push_back(mk(0,0,1, 4'h0,4'h0,0, 2'd2,2'd0, 4'hC,2'd1,1,8'h00));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,0,1, 4'h0,4'h0,0, 2'd0,2'd0, 4'hC,2'd1,1,8'h00));
    tbl.push_back(mk(0,0,1, 4'h0,4'h0,0, 2'd0,2'd0, 4'hC,2'd3,0,8'h00));
    tbl.push_back(mk(0,0,0, 4'h0,4'h0,0, 2'd0,2'd0, 4'hC,2'd3,0,8'h00));
    tbl.push_back(mk(0,1,0, 4'h5,4'hA,0, 2'd0,2'd0, 4'h5,2'd3,0,8'h00));
    tbl.push_back(mk(0,0,0, 4'h0,4'h0,0, 2'd0,2'd1, 4'h5,2'd3,1,8'h00));
    tbl.push_back(mk(0,0,0, 4'h0,4'h0,0, 2'd0,2'd0, 4'h5,2'd2,0,8'h00));
    tbl.push_back(mk(0,0,1, 4'h0,4'h0,1, 2'd0,2'd0, 4'h5,2'd2,0,8'h25));
    tbl.push_back(mk(0,0,0, 4'h0,4'h0,0, 2'd0,2'd0, 4'h5,2'd2,0,8'h00));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].wr, tbl[i].rd, tbl[i].set, tbl[i].res,
            tbl[i].stat, tbl[i].es, tbl[i].ec);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("row%0d.mode", i), 8'(mode), 8'(tbl[i].emode));
      check($sformatf("row%0d.evt", i),  8'(evt),  8'(tbl[i].eevt));
      check($sformatf("row%0d.pend", i), 8'(pend), 8'(tbl[i].epend));
      check($sformatf("row%0d.q", i),    q,        RB_EN ? tbl[i].eq : 8'h00);
    end

    // Randomized run from a fresh reset against the rule model.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 500; i++) begin
      if (i > 0) begin
        rst    = ($urandom_range(0, 59) == 0);
        if ($urandom_range(0, 9) < 3) wr = ~wr;
        if ($urandom_range(0, 9) < 3) rd = ~rd;
        stat   = 1'($urandom);
        set_cs = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'h0;
        res_cs = 4'($urandom);
        es     = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd0;
        ec     = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'd0;
      end
      @(posedge clk);
      model_step();
      @(negedge clk);
      check($sformatf("rnd%0d.mode", i), 8'(mode), 8'(m_mode));
      check($sformatf("rnd%0d.evt", i),  8'(evt),  8'(m_vis));
      check($sformatf("rnd%0d.pend", i), 8'(pend), (m_raw != m_vis) ? 8'd1 : 8'd0);
      check($sformatf("rnd%0d.q", i),    q,        8'(m_q));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/x1_mode_bank.md
X1_MODE_BANK -- requirements
Module: x1_mode_bank

Interface
REQ-001 SHALL have parameter NUM_MODES, default 4, number of set/reset mode bits (1..6).
REQ-002 SHALL have parameter NUM_EVT, default 2, number of deferred event flags (1..2); NUM_MODES+NUM_EVT <= 8.
REQ-003 SHALL have parameter MODE_RST, default 4'b0001, per-bit reset value of O_MODE (bit0 = IPL select, set at reset).
REQ-004 SHALL have parameter STALL_MAX, default 255, busy-cycle limit before a forced event update; 0 disables forcing.
REQ-005 C_CLK  in  1  sole clock, all state on rising edge.
REQ-006 I_RESET  in  1  reset, synchronous, active-high.
REQ-007 I_RD  in  1  CPU read strobe, active-high.
REQ-008 I_WR  in  1  CPU write strobe, active-high.
REQ-009 I_SET_CS  in  NUM_MODES  per-bit set chip-select, qualified by I_WR.
REQ-010 I_RES_CS  in  NUM_MODES  per-bit reset chip-select, qualified by I_WR.
REQ-011 I_STAT_CS  in  1  status readback select, qualified by I_RD.
REQ-012 I_EVT_SET  in  NUM_EVT  one-cycle set pulse per event (synchronous replacement for fall-clock set).
REQ-013 I_EVT_CLR  in  NUM_EVT  level clear per event.
REQ-014 O_MODE  out  NUM_MODES  registered mode bits.
REQ-015 O_EVT  out  NUM_EVT  visible event flags, changed only at bus-idle or forced update.
REQ-016 O_PEND  out  1  raw and visible event flags differ.
REQ-017 O_Q  out  8  status readback data.

Function
REQ-018 Write edge wr_rise = I_WR & ~wr_q, wr_q = I_WR registered; mode bits SHALL change only on wr_rise, once per write regardless of strobe length.
REQ-019 On wr_rise, bit k SHALL become 1 if I_SET_CS[k], else 0 if I_RES_CS[k], else hold; set wins when both asserted; several bits may change on one edge.
REQ-020 Raw flag evt_r[k] SHALL become 1 the edge after I_EVT_SET[k] and 0 the edge after I_EVT_CLR[k]; clear wins when both asserted in one cycle.
REQ-021 Bus idle = ~I_WR & ~I_RD; on any edge with bus idle, O_EVT SHALL load evt_r (current register value, so set pulse to O_EVT = 2 edges minimum).
REQ-022 Busy counter SHALL increment each busy cycle, reset to 0 on idle cycles, saturate at STALL_MAX.
REQ-023 When STALL_MAX != 0 and counter == STALL_MAX on a busy edge, O_EVT SHALL load evt_r and counter SHALL return to 0.
REQ-024 O_PEND SHALL be combinational (evt_r != O_EVT).
REQ-025 Counter width SHALL be clog2(STALL_MAX+1), minimum 1; no wrap beyond STALL_MAX.

Reset
REQ-026 While I_RESET high on an edge: O_MODE=MODE_RST, evt_r=0, O_EVT=0, counter=0, wr_q=1, O_Q=0.
REQ-027 wr_q reset to 1 SHALL suppress a write strobe held across reset release; only a fresh rising I_WR counts.
REQ-028 Reset SHALL override all simultaneous set, clear and write events.

Configuration
REQ-029 With X1_MODE_BANK_READBACK_EN defined, O_Q SHALL register {zeros, O_EVT, O_MODE} (O_MODE at LSBs) on edges where I_RD & I_STAT_CS, else 8'h00; data valid one edge after strobe.
REQ-030 Without X1_MODE_BANK_READBACK_EN, O_Q SHALL be constant 8'h00 and I_STAT_CS unused.

Structure
REQ-031 Package x1_mode_pkg SHALL hold readback field offsets, default STALL_MAX, and the bus-idle width constant.
REQ-032 Per-event raw/visible flag pair SHALL be sub-module x1_evt_latch, instantiated NUM_EVT times; busy counter shared at top.

Verification
REQ-033 Reset, then I_WR=1 for 3 cycles with I_SET_CS=4'b0100 -> O_MODE 0001 -> 0101 after exactly one edge, unchanged thereafter.
REQ-034 I_WR held high across reset release with I_RES_CS[0]=1 -> O_MODE stays 0001; next fresh write clears bit0 -> 0000.
REQ-035 I_EVT_SET[0] pulse with bus idle -> O_PEND=1 one edge, O_EVT[0]=1 at second edge, O_PEND=0.
REQ-036 I_EVT_SET[1] and I_EVT_CLR[1] same cycle -> evt_r[1]=0, O_EVT[1]=0, O_PEND never 1.
REQ-037 STALL_MAX=4, I_RD held high, pulse I_EVT_SET[0] -> O_EVT[0] rises at 5th busy edge, counter back to 0.
REQ-038 Macro defined, O_MODE=0101, O_EVT=10, I_RD&I_STAT_CS one cycle -> O_Q=8'h25 next edge, 8'h00 after; macro undefined -> O_Q=8'h00.
